exp_align_acc: RTL and testbench

- Downstream consumer of the 4-lane max-exponent stage in the PE datapath.
- Accepts groups of four (exponent, signed mantissa) products and finds the group maximum exponent.
- Right-aligns each mantissa to that exponent, sums the four lanes, and accumulates successive groups in a block-floating accumulator with its own running exponent.
- Emits (exponent, mantissa) per dot-product on `in_last` over a valid/ready channel.

---
 rtl/pe_fp_pkg.sv | 10 +
 rtl/align_shr.sv | 11 +
 rtl/exp_align_acc.sv | 95 +++++++++
 tb/tb_exp_align_acc.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_fp_pkg.sv
// pe_fp_pkg: shared PE datapath widths, numeric types and accumulator states
package pe_fp_pkg;
    localparam int EXP_WIDTH = 6;
    localparam int MAN_WIDTH = 8;
    localparam int ACC_WIDTH = 24;
    typedef logic [EXP_WIDTH-1:0] exp_t;
    typedef logic signed [MAN_WIDTH-1:0] man_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;
    typedef enum logic {EMPTY, ACCUM} acc_state_t;
endpackage

// File: rtl/align_shr.sv
// align_shr: arithmetic right shift whose amount saturates at W-1
module align_shr #(
    parameter int W  = pe_fp_pkg::ACC_WIDTH,
    parameter int SW = pe_fp_pkg::EXP_WIDTH
) (
    input  logic signed [W-1:0]  a,
    input  logic        [SW-1:0] sh,
    output logic signed [W-1:0]  y
);
    assign y = a >>> ((32'(sh) >= W) ? W - 1 : 32'(sh));
endmodule

// File: rtl/exp_align_acc.sv
// exp_align_acc: 4-lane exponent align, sum and block-floating accumulate; ACC_SAT_EN selects saturation over wrap
module exp_align_acc #(
    parameter int EXP_WIDTH = pe_fp_pkg::EXP_WIDTH,
    parameter int MAN_WIDTH = pe_fp_pkg::MAN_WIDTH,
    parameter int ACC_WIDTH = pe_fp_pkg::ACC_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [3:0][EXP_WIDTH-1:0]      in_exp,
    input  logic [3:0][MAN_WIDTH-1:0]      in_man,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_WIDTH-1:0]           out_exp,
    output logic [ACC_WIDTH-1:0]           out_man
);
    import pe_fp_pkg::*;
    localparam int FRAC = ACC_WIDTH - MAN_WIDTH - 3;
`ifdef ACC_SAT_EN
    localparam int XW = ACC_WIDTH + 1;
    function automatic logic signed [ACC_WIDTH-1:0] fit(input logic signed [XW-1:0] x);
        return (x[XW-1] != x[XW-2]) ? {x[XW-1], {(ACC_WIDTH-1){~x[XW-1]}}} : x[ACC_WIDTH-1:0];
    endfunction
`else
    localparam int XW = ACC_WIDTH;
    function automatic logic signed [ACC_WIDTH-1:0] fit(input logic signed [XW-1:0] x);
        return x;
    endfunction
`endif
    acc_state_t                    state;
    logic                          s1_valid, s1_last, advance;
    logic [EXP_WIDTH-1:0]          s1_exp, in_max, m01, m23, e, nxt_exp, acc_exp;
    logic [3:0][EXP_WIDTH-1:0]     in_d, s1_d;
    logic [3:0][MAN_WIDTH-1:0]     s1_man;
    logic [3:0][ACC_WIDTH-1:0]     lane_in, lane_a;
    logic signed [ACC_WIDTH-1:0]   acc, grp_sum, acc_a, grp_a, nxt_acc;
    logic signed [XW-1:0]          grp_wide, acc_wide;
    always_comb begin
        m01 = (in_exp[0] > in_exp[1]) ? in_exp[0] : in_exp[1];
        m23 = (in_exp[2] > in_exp[3]) ? in_exp[2] : in_exp[3];
        in_max = (m01 > m23) ? m01 : m23;
    end
    // a held final group may not overwrite an output the consumer has not taken
    assign advance  = s1_valid && !(s1_last && out_valid && !out_ready);
    assign in_ready = !reset && (!s1_valid || advance);
    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign in_d[g]    = in_max - in_exp[g];
        assign lane_in[g] = ACC_WIDTH'($signed(s1_man[g])) <<< FRAC;
        align_shr #(.W(ACC_WIDTH), .SW(EXP_WIDTH)) u_shr (.a(lane_in[g]), .sh(s1_d[g]), .y(lane_a[g]));
    end
    assign grp_wide = XW'($signed(lane_a[0])) + XW'($signed(lane_a[1])) +
                      XW'($signed(lane_a[2])) + XW'($signed(lane_a[3]));
    assign grp_sum  = fit(grp_wide);
    assign e        = (acc_exp > s1_exp) ? acc_exp : s1_exp;
    align_shr #(.W(ACC_WIDTH), .SW(EXP_WIDTH)) u_acc (.a(acc), .sh(e - acc_exp), .y(acc_a));
    align_shr #(.W(ACC_WIDTH), .SW(EXP_WIDTH)) u_grp (.a(grp_sum), .sh(e - s1_exp), .y(grp_a));
    assign acc_wide = XW'(acc_a) + XW'(grp_a);
    assign nxt_acc  = (state == EMPTY) ? grp_sum : fit(acc_wide);
    assign nxt_exp  = (state == EMPTY) ? s1_exp : e;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            s1_valid  <= 1'b0;
            acc       <= '0;
            acc_exp   <= '0;
            out_valid <= 1'b0;
            out_exp   <= '0;
            out_man   <= '0;
        end else begin
            if (in_valid && in_ready) begin
                s1_valid <= 1'b1;
                s1_last  <= in_last;
                s1_exp   <= in_max;
                s1_d     <= in_d;
                s1_man   <= in_man;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end
            if (advance) begin
                acc     <= nxt_acc;
                acc_exp <= nxt_exp;
                state   <= s1_last ? EMPTY : ACCUM;
            end
            if (advance && s1_last) begin
                out_valid <= 1'b1;
                out_exp   <= nxt_exp;
                out_man   <= nxt_acc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_exp_align_acc.sv
// tb_exp_align_acc: randomized and directed checks of exp_align_acc against a behavioural model
module tb_exp_align_acc;
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0][5:0]  in_exp = '0;
    logic [3:0][7:0]  in_man = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [5:0]       out_exp;
    logic [23:0]      out_man;
    int               checks = 0;
    int               errors = 0;
    bit               rand_ready = 1'b0;
    longint           m_acc = 0;
    int               m_exp = 0;
    bit               m_empty = 1'b1;
    int               want_e[$];
    longint           want_m[$];
    int               got_e[$];
    longint           got_m[$];

    exp_align_acc dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_exp(in_exp), .in_man(in_man), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_exp(out_exp), .out_man(out_man)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!reset && out_valid && out_ready) begin
            got_e.push_back(int'(out_exp));
            got_m.push_back(longint'($signed(out_man)));
        end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d want completion", $time);
        $fatal(1);
    end

    function automatic longint fitm(input longint x);
        longint y;
`ifdef ACC_SAT_EN
        y = (x > 64'sd8388607) ? 64'sd8388607 : (x < -64'sd8388608) ? -64'sd8388608 : x;
`else
        y = x & 64'hFFFFFF;
        if (y >= 64'sd8388608) y = y - 64'sd16777216;
`endif
        return y;
    endfunction

    function automatic longint shr(input longint v, input int d);
        return (d >= 24) ? ((v < 0) ? -64'sd1 : 64'sd0) : (v >>> d);
    endfunction

    task automatic model_group(input int e[4], input int m[4], input bit last);
        int g, ne;
        longint s;
        g = 0;
        s = 0;
        for (int i = 0; i < 4; i++) if (e[i] > g) g = e[i];
        for (int i = 0; i < 4; i++) s += shr(longint'(m[i]) * 8192, g - e[i]);
        s = fitm(s);
        if (m_empty) begin
            m_acc = s;
            m_exp = g;
        end else begin
            ne = (m_exp > g) ? m_exp : g;
            m_acc = fitm(shr(m_acc, ne - m_exp) + shr(s, ne - g));
            m_exp = ne;
        end
        m_empty = last;
        if (last) begin
            want_e.push_back(m_exp);
            want_m.push_back(m_acc);
        end
    endtask

    task automatic clear_all();
        want_e.delete();
        want_m.delete();
        got_e.delete();
        got_m.delete();
    endtask

    task automatic send(input int e[4], input int m[4], input bit last);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_exp[i] = 6'(e[i]);
            in_man[i] = 8'(m[i]);
        end
        in_last  = last;
        in_valid = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_accept: in_ready stayed %0b, want 1 within 200 cycles", in_ready);
        end else begin
            model_group(e, m, last);
        end
    endtask

    task automatic drain(input int n);
        rand_ready = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 300 && got_e.size() < n; c++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (got_e.size() !== n) begin
            errors++;
            $display("FAIL result_count: got %0d results, want %0d", got_e.size(), n);
        end
    endtask

    task automatic check_result(input string name, input int idx, input int ee, input longint em);
        checks++;
        if (idx >= got_e.size() || got_e[idx] !== ee || got_m[idx] !== em) begin
            errors++;
            if (idx >= got_e.size())
                $display("FAIL %s: no result %0d, want exp %0d man %0d", name, idx, ee, em);
            else
                $display("FAIL %s: got exp %0d man %0d, want exp %0d man %0d", name, got_e[idx], got_m[idx], ee, em);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++;
        if (out_exp !== 6'd0) begin errors++; $display("FAIL reset_out_exp: got %0d want 0", out_exp); end
        checks++;
        if (out_man !== 24'd0) begin errors++; $display("FAIL reset_out_man: got %0d want 0", out_man); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %0b want 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        clear_all();
        out_ready = 1'b1;
        send('{10, 10, 10, 10}, '{1, 2, 3, 4}, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: out_valid %0b one edge after accept, want 0", out_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL latency: out_valid %0b two edges after accept, want 1", out_valid); end
        send('{12, 10, 10, 10}, '{4, 4, 4, 4}, 1'b1);
        send('{10, 10, 10, 10}, '{1, 0, 0, 0}, 1'b0);
        send('{11, 11, 11, 11}, '{1, 0, 0, 0}, 1'b1);
        drain(3);
        check_result("equal_exps", 0, 10, 81920);
        check_result("mixed_exps", 1, 12, 57344);
        check_result("exp_growth", 2, 11, 12288);
    endtask

    task automatic test_overflow();
        clear_all();
        send('{5, 5, 5, 5}, '{127, 127, 127, 127}, 1'b0);
        send('{5, 5, 5, 5}, '{127, 127, 127, 127}, 1'b0);
        send('{5, 5, 5, 5}, '{127, 127, 127, 127}, 1'b1);
        drain(1);
`ifdef ACC_SAT_EN
        check_result("overflow_sat", 0, 5, 8388607);
`else
        check_result("overflow_wrap", 0, 5, -4292608);
`endif
        check_result("overflow_model", 0, want_e[0], want_m[0]);
    endtask

    task automatic test_backpressure();
        clear_all();
        out_ready = 1'b0;
        send('{10, 10, 10, 10}, '{1, 0, 0, 0}, 1'b1);
        send('{7, 7, 7, 7}, '{-3, 0, 0, 0}, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0b want 0 with result held", in_ready); end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_exp !== 6'd10 || out_man !== 24'd8192) begin
                errors++;
                $display("FAIL bp_hold: got valid %0b exp %0d man %0d, want 1 10 8192", out_valid, out_exp, out_man);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        drain(2);
        check_result("bp_first", 0, 10, 8192);
        check_result("bp_second", 1, 7, -24576);
    endtask

    task automatic test_reset_mid();
        clear_all();
        out_ready = 1'b1;
        send('{4, 4, 4, 4}, '{5, 5, 5, 5}, 1'b0);
        send('{6, 2, 4, 1}, '{-7, 9, 3, 1}, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got in_ready %0b out_valid %0b, want 0 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        m_empty = 1'b1;
        clear_all();
        send('{3, 3, 3, 3}, '{2, 0, 0, 0}, 1'b1);
        drain(1);
        check_result("after_reset", 0, 3, 16384);
    endtask

    task automatic test_random();
        int e[4], m[4], n, base;
        clear_all();
        rand_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(1, 4);
            for (int g = 0; g < n; g++) begin
                base = $urandom_range(0, 60);
                for (int i = 0; i < 4; i++) begin
                    e[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : base + int'($urandom_range(0, 3));
                    m[i] = int'($urandom_range(0, 255)) - 128;
                end
                send(e, m, g == n - 1);
            end
        end
        drain(want_e.size());
        for (int i = 0; i < want_e.size(); i++)
            check_result($sformatf("random_%0d", i), i, want_e[i], want_m[i]);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
